// File: rtl/serial_adder.sv
// Multi-cycle adder: STEP bits per clock, LSB first, one carry flop between slices.
// Define SERIAL_ADDER_SUB_EN to add the i_sub port (A-B via inverted B and carry-in of 1).
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  // state | meaning
  // IDLE  | waiting for i_start; result registers hold the last result
  // ADD   | one STEP-bit slice per edge, N edges in total
  // DONE  | result valid, o_done high for this cycle only

  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);

  if (WIDTH < 2 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_param_check
    $error("serial_adder: WIDTH must be >= 2 and a multiple of STEP");
  end

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, busy_q, done_q;
  logic [STEP:0]    slice;
  logic [WIDTH-1:0] slice_ext;
  logic [WIDTH-1:0] b_start;
  logic             cin_start;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_start   = i_sub ? ~i_b : i_b;
  assign cin_start = i_sub | i_carry;
`else
  assign b_start   = i_b;
  assign cin_start = i_carry;
`endif

  assign slice     = {1'b0, a_q[STEP-1:0]} + {1'b0, b_q[STEP-1:0]} + {{STEP{1'b0}}, carry_q};
  assign slice_ext = WIDTH'(slice[STEP-1:0]);
  // Each slice enters at the MSB end; after N steps the first slice sits at bit 0.
  assign sum_d     = (sum_q >> STEP) | (slice_ext << (WIDTH - STEP));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (i_start) begin
            a_q     <= i_a;
            b_q     <= b_start;
            carry_q <= cin_start;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ADD;
          end
        end
        S_ADD: begin
          a_q     <= a_q >> STEP;
          b_q     <= b_q >> STEP;
          carry_q <= slice[STEP];
          cout_q  <= slice[STEP];
          sum_q   <= sum_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_sum   = sum_q;
  assign o_carry = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8/STEP=1 and WIDTH=16/STEP=4 instances against an arithmetic model.
module tb_serial_adder;

`ifdef SERIAL_ADDER_SUB_EN
  localparam bit SUB_ON = 1'b1;
`else
  localparam bit SUB_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8, start8, cin8, sub8, busy8, done8, c8;
  logic [7:0]  a8, b8, sum8;
  logic        rst16, start16, cin16, sub16, busy16, done16, c16;
  logic [15:0] a16, b16, sum16;

  serial_adder #(.WIDTH(8), .STEP(1)) dut8 (
    .i_clk(clk), .i_rst(rst8), .i_start(start8), .i_a(a8), .i_b(b8), .i_carry(cin8),
`ifdef SERIAL_ADDER_SUB_EN
    .i_sub(sub8),
`endif
    .o_busy(busy8), .o_done(done8), .o_sum(sum8), .o_carry(c8)
  );

  serial_adder #(.WIDTH(16), .STEP(4)) dut16 (
    .i_clk(clk), .i_rst(rst16), .i_start(start16), .i_a(a16), .i_b(b16), .i_carry(cin16),
`ifdef SERIAL_ADDER_SUB_EN
    .i_sub(sub16),
`endif
    .o_busy(busy16), .o_done(done16), .o_sum(sum16), .o_carry(c16)
  );

  // phase: 0 idle, 1..n adding, n+1 done; res/rc is the pending result, sum/c the visible one.
  typedef struct {
    int          phase;
    logic [15:0] res;
    logic        rc;
    logic [15:0] sum;
    logic        c;
  } mdl_t;

  mdl_t m8  = '{default: 0};
  mdl_t m16 = '{default: 0};
  int vectors = 0;
  int errors  = 0;

  function automatic mdl_t mstep(mdl_t m, int n, int w, logic st, logic [15:0] a,
                                 logic [15:0] b, logic cin, logic sub);
    logic [16:0] full;
    logic [15:0] mask;
    mask = 16'((17'd1 << w) - 17'd1);
    if (m.phase == 0) begin
      if (st) begin
        if (sub) begin
          m.res = (a - b) & mask;
          m.rc  = (a >= b);
        end else begin
          full  = {1'b0, a} + {1'b0, b} + 17'(cin);
          m.res = full[15:0] & mask;
          m.rc  = full[w];
        end
        m.phase = 1;
      end
    end else if (m.phase < n) begin
      m.phase++;
    end else if (m.phase == n) begin
      m.phase = n + 1;
      m.sum   = m.res;
      m.c     = m.rc;
    end else begin
      m.phase = 0;
    end
    return m;
  endfunction

  always @(posedge clk or posedge rst8)
    if (rst8) m8 = '{default: 0};
    else      m8 = mstep(m8, 8, 8, start8, 16'(a8), 16'(b8), cin8, sub8 & SUB_ON);

  always @(posedge clk or posedge rst16)
    if (rst16) m16 = '{default: 0};
    else       m16 = mstep(m16, 4, 16, start16, a16, b16, cin16, sub16 & SUB_ON);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("busy8", 32'(busy8), 32'(m8.phase >= 1 && m8.phase <= 8));
    chk("done8", 32'(done8), 32'(m8.phase == 9));
    if (m8.phase == 0 || m8.phase == 1 || m8.phase == 9) begin
      chk("sum8", 32'(sum8), 32'(m8.sum[7:0]));
      chk("carry8", 32'(c8), 32'(m8.c));
    end
    chk("busy16", 32'(busy16), 32'(m16.phase >= 1 && m16.phase <= 4));
    chk("done16", 32'(done16), 32'(m16.phase == 5));
    if (m16.phase == 0 || m16.phase == 1 || m16.phase == 5) begin
      chk("sum16", 32'(sum16), 32'(m16.sum));
      chk("carry16", 32'(c16), 32'(m16.c));
    end
  end

  // One 8-bit operation; cycle 0 is the cycle start is presented, done expected in cycle 9.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                     input logic [7:0] es, input logic ec, input int glitch, input int rstc);
    int cyc, busyc, extra;
    bit got;
    busyc = 0; got = 0; extra = 0;
    @(posedge clk); #1;
    a8 = a; b8 = b; cin8 = cin; sub8 = sub; start8 = 1'b1;
    for (cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (busy8) busyc++;
      if (done8) begin got = 1; break; end
      if (cyc == 1) begin
        #2 start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
      if (cyc == glitch) begin
        #2 start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      end
      if (cyc == glitch + 1) begin
        #2 start8 = 1'b0;
      end
      if (cyc == rstc) begin
        #2 rst8 = 1'b1;
        break;
      end
    end
    if (rstc >= 0) begin
      #1;
      chk("rst_async_busy", 32'(busy8), 32'd0);
      chk("rst_async_done", 32'(done8), 32'd0);
      chk("rst_async_sum", 32'(sum8), 32'd0);
      chk("rst_async_carry", 32'(c8), 32'd0);
      @(posedge clk); @(posedge clk); #1 rst8 = 1'b0;
    end else begin
      chk("done8_seen", 32'(got), 32'd1);
      chk("latency8", cyc, 32'd9);
      chk("busy_cycles8", busyc, 32'd8);
      chk("lit_sum8", 32'(sum8), 32'(es));
      chk("lit_carry8", 32'(c8), 32'(ec));
      chk("model_sum8", 32'(m8.sum[7:0]), 32'(es));
      chk("model_carry8", 32'(m8.c), 32'(ec));
      @(negedge clk);
      chk("done8_pulse", 32'(done8), 32'd0);
    end
    repeat (12) begin
      @(negedge clk);
      if (done8) extra++;
    end
    chk("extra_done8", extra, 32'd0);
  endtask

  task automatic op16_held(input int ops);
    int cyc, last, seen;
    last = -1; seen = 0;
    @(posedge clk); #1;
    a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0; sub16 = 1'b0; start16 = 1'b1;
    for (cyc = 0; cyc < 200 && seen < ops; cyc++) begin
      @(negedge clk);
      if (done16) begin
        if (last < 0) chk("latency16", cyc, 32'd5);
        else          chk("period16", cyc - last, 32'd6);
        chk("lit_sum16", 32'(sum16), 32'h0000);
        chk("lit_carry16", 32'(c16), 32'd1);
        last = cyc;
        seen++;
      end
    end
    chk("held_ops16", seen, ops);
    #2 start16 = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    rst8 = 1'b1; rst16 = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst8 = 1'b0; rst16 = 1'b0;
    @(negedge clk);
    chk("reset_sum8", 32'(sum8), 32'd0);
    chk("reset_busy8", 32'(busy8), 32'd0);
    chk("reset_sum16", 32'(sum16), 32'd0);

    op8(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, -10, -10);
    op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, -10, -10);
    op8(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, -10, -10);
    op8(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, -10, -10);
    op8(8'h21, 8'h13, 1'b0, 1'b0, 8'h34, 1'b0, 3, -10);
    op8(8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, -10, 4);
    op8(8'h3C, 8'h5A, 1'b1, 1'b0, 8'h97, 1'b0, -10, -10);
    if (SUB_ON) begin
      op8(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, -10, -10);
      op8(8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, -10, -10);
    end

    op16_held(1);
    op16_held(4);

    repeat (1500) begin
      @(posedge clk); #1;
      start8  = ($urandom_range(0, 2) == 0);
      a8      = 8'($urandom); b8 = 8'($urandom);
      cin8    = 1'($urandom_range(0, 1)); sub8 = 1'($urandom_range(0, 1));
      rst8    = ($urandom_range(0, 149) == 0);
      start16 = ($urandom_range(0, 2) == 0);
      a16     = 16'($urandom); b16 = 16'($urandom);
      cin16   = 1'($urandom_range(0, 1)); sub16 = 1'($urandom_range(0, 1));
      rst16   = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #1;
    start8 = 1'b0; start16 = 1'b0; rst8 = 1'b0; rst16 = 1'b0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
